// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module  : logic_unit_pipe
// Purpose : Two-stage pipelined bitwise logic unit (8 ops) with result flags,
//           valid/ready handshakes and a completed-transfer counter.
// Rev     : 1.0
// ============================================================================
module logic_unit_pipe #(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  result,
  output logic          zero,
  output logic          ones,
  output logic          parity,
  output logic [CW-1:0] done_cnt
);

  localparam logic [2:0] c_op_not  = 3'b000;
  localparam logic [2:0] c_op_and  = 3'b001;
  localparam logic [2:0] c_op_or   = 3'b010;
  localparam logic [2:0] c_op_xor  = 3'b011;
  localparam logic [2:0] c_op_nand = 3'b100;
  localparam logic [2:0] c_op_nor  = 3'b101;
  localparam logic [2:0] c_op_xnor = 3'b110;
  localparam logic [2:0] c_op_pass = 3'b111;

  // Stage 1 registers
  logic          v1_q, v1_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;

  // Stage 2 registers
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  result_q, result_d;
  logic          zero_q, zero_d;
  logic          ones_q, ones_d;
  logic          parity_q, parity_d;
  logic [CW-1:0] done_cnt_q, done_cnt_d;

  logic          w_s1_en;
  logic          w_s2_en;
  logic          w_in_xfer;
  logic          w_out_xfer;
  logic [W-1:0]  w_op_res;

  // Each stage may load when its downstream neighbour frees up this cycle.
  always_comb begin
    w_s2_en    = !out_valid_q | out_ready;
    w_s1_en    = !v1_q | w_s2_en;
    w_in_xfer  = in_valid & w_s1_en;
    w_out_xfer = out_valid_q & out_ready;
  end

  always_comb begin
    w_op_res = a_q;
    case (op_q)
      c_op_not:  w_op_res = ~a_q;
      c_op_and:  w_op_res = a_q & b_q;
      c_op_or:   w_op_res = a_q | b_q;
      c_op_xor:  w_op_res = a_q ^ b_q;
      c_op_nand: w_op_res = ~(a_q & b_q);
      c_op_nor:  w_op_res = ~(a_q | b_q);
      c_op_xnor: w_op_res = ~(a_q ^ b_q);
      c_op_pass: w_op_res = a_q;
      default:   w_op_res = a_q;
    endcase
  end

  always_comb begin
    v1_d        = v1_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ones_d      = ones_q;
    parity_d    = parity_q;
    done_cnt_d  = done_cnt_q;

    if (w_s1_en) begin
      v1_d = w_in_xfer;
      if (w_in_xfer) begin
        op_d = op;
        a_d  = a;
        b_d  = b;
      end
    end

    // Flags are derived from the very value being registered as result.
    if (w_s2_en) begin
      out_valid_d = v1_q;
      result_d    = w_op_res;
      zero_d      = (w_op_res == '0);
      ones_d      = &w_op_res;
      parity_d    = ^w_op_res;
    end

    if (w_out_xfer) begin
      done_cnt_d = done_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      ones_q      <= 1'b0;
      parity_q    <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      v1_q        <= v1_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ones_q      <= ones_d;
      parity_q    <= parity_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign in_ready  = w_s1_en;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ones      = ones_q;
  assign parity    = parity_q;
  assign done_cnt  = done_cnt_q;

endmodule
`default_nettype wire
